// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level helpers for the forward cipher.
package aes_pkg;

  typedef logic [127:0] aes_blk_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_e;

  localparam int NR = 10;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte idx of the column-major state; byte 0 sits in bits [127:120].
  function automatic logic [7:0] blk_byte(input aes_blk_t b, input int idx);
    return b[127-8*idx -: 8];
  endfunction

  // One step of the AES-128 key schedule: previous round key -> next round key.
  function automatic aes_blk_t key_expand(input aes_blk_t k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// Combinational forward AES round: SubBytes, ShiftRows, MixColumns (skipped on last), AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  aes_blk_t state,
  input  aes_blk_t rkey,
  input  logic     last,
  output aes_blk_t next
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0]  s [4];
    logic [31:0] mix, col;

    // Row r of output column c comes from input column (c+r) mod 4.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign s[r] = sbox(blk_byte(state, 4*((c+r)%4) + r));
    end

    assign mix = {xtime(s[0]) ^ xtime(s[1]) ^ s[1] ^ s[2] ^ s[3],
                  s[0] ^ xtime(s[1]) ^ xtime(s[2]) ^ s[2] ^ s[3],
                  s[0] ^ s[1] ^ xtime(s[2]) ^ xtime(s[3]) ^ s[3],
                  xtime(s[0]) ^ s[0] ^ s[1] ^ s[2] ^ xtime(s[3])};
    assign col = last ? {s[0], s[1], s[2], s[3]} : mix;
    assign next[127-32*c -: 32] = col ^ rkey[127-32*c -: 32];
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, key schedule expanded on the fly.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_out
);

  aes_state_e fsm;
  aes_blk_t   state_q, rkey_q, rkey_nxt, round_out;
  logic [3:0] rnd;

  assign rkey_nxt = key_expand(rkey_q, rcon(rnd));

  aes_enc_round u_round (
    .state (state_q),
    .rkey  (rkey_nxt),
    .last  (rnd == 4'(NR)),
    .next  (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state_q   <= '0;
      rkey_q    <= '0;
      rnd       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ct_out    <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          state_q  <= pt_in ^ key_in;
          rkey_q   <= key_in;
          rnd      <= 4'd1;
          in_ready <= 1'b0;
          fsm      <= RUN;
        end
        RUN: begin
          state_q <= round_out;
          rkey_q  <= rkey_nxt;
          if (rnd == 4'(NR)) begin
            ct_out    <= round_out;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          fsm       <= IDLE;
          if (ZEROIZE) begin
            state_q <= '0;
            rkey_q  <= '0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
